dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Responder end of the datapath/cache data-port protocol; services dmemREN/dmemWEN/datomic requests from the pipelined datapath.
- Returns dhit and dmemload to the datapath.
- Direct-mapped, one-word-block, write-through, read-allocate data cache between datapath and memory controller.
- Holds the LL/SC link register and performs the invalidate sequence on halt, then raises flushed.

Parameters:
SETS, 8, number of cache lines; power of two, >=2; IDX = log2(SETS)
TAG_W, 30-log2(SETS), tag width; tag = dmemaddr[31:2+IDX], index = dmemaddr[1+IDX:2]

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
halt  in  1  datapath halted; starts flush
dmemREN  in  1  datapath read request
dmemWEN  in  1  datapath write request
datomic  in  1  qualifies request as LL (with REN) or SC (with WEN)
dmemaddr  in  32  word address; bits [1:0] ignored
dmemstore  in  32  write data
dhit  out  1  request complete this cycle
dmemload  out  32  read data; SC result (1 success, 0 fail)
flushed  out  1  flush complete; sticky until RST
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory address, {dmemaddr[31:2],2'b00}
dstore  out  32  memory write data
dwait  in  1  memory busy; transfer completes in first cycle dwait=0 while dREN/dWEN high
dload  in  32  memory read data, valid when dwait=0

Behaviour:
- Reset (RST high at edge): state IDLE; all valid bits 0; link_valid 0; flush counter 0. All outputs 0 while RST is high, and in the first cycle after reset.
- States: IDLE, FILL, WRITE, FLUSH, DONE.
- IDLE:
  - Read hit (dmemREN & !dmemWEN & valid[idx] & tag match & !halt): dhit=1 combinationally, same cycle. dmemload=data[idx]. Zero-cycle latency. dhit stays high while the request is held.
  - Read miss: next state FILL.
  - Any dmemWEN (non-SC, or SC that passes the link check): next state WRITE.
  - dmemWEN and dmemREN both high: treated as a write; the read is ignored.
- FILL:
  - dREN=1, daddr=aligned dmemaddr.
  - On dwait=0: dhit=1 and dmemload=dload that cycle. Line written (valid=1, tag, data). Return to IDLE.
- WRITE:
  - dWEN=1, daddr, dstore=dmemstore.
  - On dwait=0: dhit=1. If the line hits, its data is updated (write-update). No allocate on a write miss. Return to IDLE.
- LL (datomic & dmemREN): handled as a normal read. In the dhit cycle, link_valid<=1 and link_addr<=dmemaddr[31:2].
- SC (datomic & dmemWEN):
  - Success (link_valid & link_addr==dmemaddr[31:2]): WRITE path. In the dhit cycle, dmemload=1 and link_valid<=0.
  - Failure: in IDLE, dhit=1 same cycle with dmemload=0. No memory access; cache unchanged.
- Link invalidation: any completed non-SC write to link_addr clears link_valid. A completed write to another address leaves it unchanged.
- Halt:
  - halt=1 in IDLE → FLUSH. No new requests are accepted from then on.
  - halt asserted during FILL/WRITE: the transfer completes first, then FLUSH.
- FLUSH:
  - Clears valid[cnt] each cycle, cnt 0..SETS-1, no memory traffic (write-through).
  - After clearing SETS-1 → DONE. Takes exactly SETS cycles.
- DONE: flushed=1; dhit, dREN, dWEN=0. Held until RST.
- dREN/dWEN never both high. daddr/dstore stay stable while dwait=1.
- Datapath dropping its request mid-FILL/WRITE is illegal: the transfer still completes, with dhit pulsed.
- RST mid-FILL/WRITE/FLUSH: immediate return to reset state at that edge. Memory request dropped.

Test Plan:
- Reset, then dmemREN addr 0x40, dwait=1 for 3 cycles, dload=0xDEADBEEF → dREN high 4 cycles, dhit 1 cycle with dmemload=0xDEADBEEF. A repeat read of 0x40 → dhit same cycle, no dREN.
- Write 0x40 data 0x12345678 with dwait=0 → dWEN one cycle, daddr=0x40, dhit next cycle. A subsequent read of 0x40 hits, returning 0x12345678.
- Conflicting address 0x40+4*SETS read after 0x40 → miss, FILL. A re-read of 0x40 misses again (eviction).
- LL 0x80, then SC 0x80 data 5 → dWEN, dmemload=1. A second SC 0x80 → dhit same cycle, dmemload=0, no dWEN.
- LL 0x80, then SW 0x80, then SC 0x80 → SC fails, dmemload=0. LL 0x80, SW 0x84, SC 0x80 → success.
- halt during FILL (dwait=1) → FILL completes with dhit, then 8 FLUSH cycles, then flushed=1 held. Read of 0x40 after RST misses.

Source files
------------

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through data cache responder with LL/SC link and halt flush
module dcache_responder #(
  parameter int SETS  = 8,
  parameter int TAG_W = 30 - $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);
  localparam int IDX = $clog2(SETS);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, FLUSH, DONE} state_t;
  state_t state, state_nx;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_arr  [SETS];
  logic [31:0]      data_arr [SETS];
  logic             link_valid;
  logic [29:0]      link_addr;
  logic [IDX-1:0]   cnt;
  logic             boot;
  logic             halt_pend;

  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] tag;
  logic             line_hit, sc_ok, quiet, unused_ok;
  logic             hit_c, ren_c, wen_c, fill_done, write_done, ll_set;
  logic [31:0]      load_c, store_c;

  assign idx       = dmemaddr[1+IDX:2];
  assign tag       = dmemaddr[31:2+IDX];
  assign line_hit  = valid[idx] && (tag_arr[idx] == tag);
  assign sc_ok     = link_valid && (link_addr == dmemaddr[31:2]);
  assign unused_ok = &{1'b0, dmemaddr[1:0]};
  // Outputs are silenced during reset and for the single cycle following it.
  assign quiet     = RST || boot;

  always_comb begin
    state_nx   = state;
    hit_c      = 1'b0;
    load_c     = '0;
    ren_c      = 1'b0;
    wen_c      = 1'b0;
    store_c    = '0;
    fill_done  = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: if (!boot) begin
        if (halt) state_nx = FLUSH;
        else if (dmemWEN) begin
          if (datomic && !sc_ok) hit_c = 1'b1;  // failed SC answers at once with 0
          else state_nx = WRITE;
        end else if (dmemREN) begin
          if (line_hit) begin
            hit_c  = 1'b1;
            load_c = data_arr[idx];
          end else state_nx = FILL;
        end
      end
      FILL: begin
        ren_c = 1'b1;
        if (!dwait) begin
          hit_c     = 1'b1;
          load_c    = dload;
          fill_done = 1'b1;
          state_nx  = (halt || halt_pend) ? FLUSH : IDLE;
        end
      end
      WRITE: begin
        wen_c   = 1'b1;
        store_c = dmemstore;
        if (!dwait) begin
          hit_c      = 1'b1;
          load_c     = {31'b0, datomic};
          write_done = 1'b1;
          state_nx   = (halt || halt_pend) ? FLUSH : IDLE;
        end
      end
      FLUSH: if (cnt == IDX'(SETS-1)) state_nx = DONE;
      DONE: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign ll_set   = hit_c && datomic && dmemREN && !dmemWEN;
  assign dhit     = hit_c && !quiet;
  assign dmemload = quiet ? 32'h0 : load_c;
  assign dREN     = ren_c && !quiet;
  assign dWEN     = wen_c && !quiet;
  assign daddr    = (!quiet && (ren_c || wen_c)) ? {dmemaddr[31:2], 2'b00} : 32'h0;
  assign dstore   = quiet ? 32'h0 : store_c;
  assign flushed  = (state == DONE) && !quiet;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      link_valid <= 1'b0;
      link_addr  <= '0;
      cnt        <= '0;
      boot       <= 1'b1;
      halt_pend  <= 1'b0;
    end else begin
      state <= state_nx;
      boot  <= 1'b0;
      if ((state == FILL || state == WRITE) && halt) halt_pend <= 1'b1;
      if (fill_done) valid[idx] <= 1'b1;
      if (write_done && (datomic || link_addr == dmemaddr[31:2])) link_valid <= 1'b0;
      if (ll_set) begin
        link_valid <= 1'b1;
        link_addr  <= dmemaddr[31:2];
      end
      if (state == FLUSH) begin
        valid[cnt] <= 1'b0;
        cnt        <= cnt + IDX'(1);
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (!RST && fill_done) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= dload;
    end else if (!RST && write_done && line_hit) begin
      data_arr[idx] <= dmemstore;
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - directed scoreboard bench for dcache_responder
module tb_dcache_responder;
  localparam int SETS = 8;

  logic        CLK = 1'b0, RST = 1'b1, halt = 1'b0;
  logic        dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0, dwait = 1'b1;
  logic [31:0] dmemaddr = '0, dmemstore = '0, dload = '0;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;

  int total = 0;
  int bad   = 0;

  typedef struct {logic chk; logic [31:0] val;} exp_t;
  exp_t        sb_q[$];
  logic [31:0] mem [logic [31:0]];

  always #5 CLK = ~CLK;

  dcache_responder #(.SETS(SETS)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic check_quiet(input string nm);
    check({nm, "/outs"}, {28'h0, dhit, dREN, dWEN, flushed}, 32'h0);
    check({nm, "/daddr"}, daddr, 32'h0);
    check({nm, "/dmemload"}, dmemload, 32'h0);
  endtask

  // Holds one request until dhit; plays memory with `waits` busy cycles.
  task automatic do_req(input string nm, input logic ren, input logic wen, input logic atom,
                        input logic [31:0] addr, input logic [31:0] data, input int waits,
                        input logic exp_mem, input logic chk, input logic [31:0] exp_val,
                        input int halt_at);
    int    cyc, memcyc, lat;
    logic  got;
    exp_t  e;
    logic [31:0] al;
    al = {addr[31:2], 2'b00};
    sb_q.push_back('{chk, exp_val});
    dmemREN = ren; dmemWEN = wen; datomic = atom; dmemaddr = addr; dmemstore = data;
    cyc = 0; memcyc = 0; got = 1'b0; lat = -1;
    while (!got && cyc < 40) begin
      if (cyc == halt_at) halt = 1'b1;
      #1;
      if (dREN || dWEN) begin
        if (memcyc == 0) begin
          check({nm, "/daddr"}, daddr, al);
          check({nm, "/kind"}, {30'h0, dREN, dWEN}, wen ? 32'h1 : 32'h2);
          if (wen) check({nm, "/dstore"}, dstore, data);
        end
        dwait = (memcyc < waits);
        dload = dwait ? 32'h0 : mem_rd(al);
        memcyc++;
      end else begin
        dwait = 1'b1;
      end
      #1;
      if (dhit) begin
        got = 1'b1;
        lat = cyc;
        if (sb_q.size() == 0) check({nm, "/sb_empty"}, 32'h1, 32'h0);
        else begin
          e = sb_q.pop_front();
          if (e.chk) check({nm, "/dmemload"}, dmemload, e.val);
        end
      end
      step();
      cyc++;
    end
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0; dwait = 1'b1;
    check({nm, "/dhit_seen"}, {31'h0, got}, 32'h1);
    check({nm, "/latency"}, 32'(lat), exp_mem ? 32'(waits + 1) : 32'h0);
    check({nm, "/mem_cycles"}, 32'(memcyc), exp_mem ? 32'(waits + 1) : 32'h0);
    if (wen && exp_mem) mem[al] = data;
  endtask

  initial begin
    int n, busy;
    mem[32'h40]  = 32'hDEADBEEF;
    mem[32'h60]  = 32'hA5A50060;
    mem[32'h80]  = 32'h11110080;
    mem[32'hC0]  = 32'h220000C0;
    mem[32'h100] = 32'h33330100;

    dmemREN = 1'b1; dmemaddr = 32'h44;
    step(); step();
    check_quiet("in_reset");
    RST = 1'b0; dmemREN = 1'b0; dmemaddr = '0;
    #1 check_quiet("boot");
    step();

    do_req("rd40_miss", 1, 0, 0, 32'h40, 0, 3, 1, 1, 32'hDEADBEEF, -1);
    do_req("rd40_hit",  1, 0, 0, 32'h40, 0, 0, 0, 1, 32'hDEADBEEF, -1);
    do_req("sw40",      0, 1, 0, 32'h40, 32'h12345678, 0, 1, 0, 0, -1);
    do_req("rd40_upd",  1, 0, 0, 32'h40, 0, 0, 0, 1, 32'h12345678, -1);
    do_req("rd60_conf", 1, 0, 0, 32'h60, 0, 1, 1, 1, 32'hA5A50060, -1);
    do_req("rd40_evict", 1, 0, 0, 32'h40, 0, 0, 1, 1, 32'h12345678, -1);
    do_req("sw_c0_miss", 0, 1, 0, 32'hC0, 32'h0000C0C0, 0, 1, 0, 0, -1);
    do_req("rd_c0_noalloc", 1, 0, 0, 32'hC0, 0, 0, 1, 1, 32'h0000C0C0, -1);

    do_req("ll80",      1, 0, 1, 32'h80, 0, 2, 1, 1, 32'h11110080, -1);
    do_req("sc80_ok",   0, 1, 1, 32'h80, 32'h5, 1, 1, 1, 32'h1, -1);
    do_req("sc80_fail", 0, 1, 1, 32'h80, 32'h6, 0, 0, 1, 32'h0, -1);
    do_req("ll80_b",    1, 0, 1, 32'h80, 0, 0, 0, 1, 32'h5, -1);
    do_req("sw80",      0, 1, 0, 32'h80, 32'h7, 0, 1, 0, 0, -1);
    do_req("sc80_brk",  0, 1, 1, 32'h80, 32'h9, 0, 0, 1, 32'h0, -1);
    do_req("ll80_c",    1, 0, 1, 32'h80, 0, 0, 0, 1, 32'h7, -1);
    do_req("sw84",      0, 1, 0, 32'h84, 32'h84, 0, 1, 0, 0, -1);
    do_req("sc80_keep", 0, 1, 1, 32'h80, 32'hB, 0, 1, 1, 32'h1, -1);
    do_req("rd80_sc",   1, 0, 0, 32'h80, 0, 0, 0, 1, 32'hB, -1);
    do_req("rw_both",   1, 1, 0, 32'h60, 32'h6060, 0, 1, 0, 0, -1);

    do_req("rd100_halt", 1, 0, 0, 32'h100, 0, 3, 1, 1, 32'h33330100, 2);
    n = 0; busy = 0;
    while (!flushed && n < 20) begin
      if (dREN || dWEN || dhit) busy++;
      step();
      n++;
    end
    check("flush_cycles", 32'(n), 32'(SETS));
    check("flush_quiet", 32'(busy), 32'h0);
    dmemREN = 1'b1; dmemaddr = 32'h80;
    step(); step();
    check("done_held", {29'h0, flushed, dhit, dREN}, 32'h4);
    dmemREN = 1'b0;

    RST = 1'b1; halt = 1'b0;
    #1 check_quiet("reset2");
    step();
    RST = 1'b0;
    step();
    do_req("rd40_post_rst", 1, 0, 0, 32'h40, 0, 0, 1, 1, 32'h12345678, -1);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
